// File: rtl/alu_pkg.sv
// Shared opcode definitions for the two-stage ALU pipeline.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/alu_pipe_reg.sv
// One pipeline slot: a valid bit plus a data word, advanced by a load enable.
// Data is only captured alongside a valid entry so an empty slot keeps its
// last payload visible rather than picking up bubble garbage.
module alu_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         vld_in,
    input  logic [W-1:0] data_in,
    output logic         vld_out,
    output logic [W-1:0] data_out
);

    logic         vld_d;
    logic         vld_q;
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next-state: hold unless the slot is allowed to advance.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load) begin
            vld_d = vld_in;
            if (vld_in) begin
                data_d = data_in;
            end
        end
    end

    // Slot register; reset clears both the valid bit and the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_out  = vld_q;
    assign data_out = data_q;

endmodule

// File: rtl/alu_pipe_stage.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures opcode and operands; stage 2 captures result and flags.
module alu_pipe_stage
    import alu_pkg::*;
#(
    parameter int n = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [n-1:0]    in_a,
    input  logic [n-1:0]    in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [n-1:0]    out_result,
    output logic            out_zero,
    output logic            out_carry,
    output logic            out_overflow
);

    localparam int S1_W = OP_W + 2 * n;
    localparam int S2_W = n + 3;

    logic              s1_adv;
    logic              s2_adv;

    logic              vld_p1;
    logic [S1_W-1:0]   data_p1;
    logic [OP_W-1:0]   op_p1;
    logic [n-1:0]      a_p1;
    logic [n-1:0]      b_p1;

    logic              vld_p2;
    logic [S2_W-1:0]   data_p2;

    logic              is_sub;
    logic [n-1:0]      b_eff;
    logic [n:0]        sum;
    logic              add_ovf;
    logic              slt_bit;
    logic [n-1:0]      result_d;
    logic              zero_d;
    logic              carry_d;
    logic              ovf_d;

    // Stage 2 frees up when empty or being consumed; stage 1 when it can
    // empty into stage 2. No path from in_valid into in_ready.
    always_comb begin
        s2_adv   = !vld_p2 || out_ready;
        s1_adv   = !vld_p1 || s2_adv;
        in_ready = s1_adv;
    end

    // ---- stage 1: opcode and operands ----
    alu_pipe_reg #(.W(S1_W)) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .load     (s1_adv),
        .vld_in   (in_valid),
        .data_in  ({in_op, in_a, in_b}),
        .vld_out  (vld_p1),
        .data_out (data_p1)
    );

    assign {op_p1, a_p1, b_p1} = data_p1;

    // Shared n+1 bit adder for ADD/SUB/SLT plus the 8:1 result mux.
    always_comb begin
        is_sub  = (op_p1 == OP_SUB) || (op_p1 == OP_SLT);
        b_eff   = is_sub ? ~b_p1 : b_p1;
        sum     = {1'b0, a_p1} + {1'b0, b_eff} + {{n{1'b0}}, is_sub};
        add_ovf = (a_p1[n-1] == b_eff[n-1]) && (sum[n-1] != a_p1[n-1]);
        slt_bit = sum[n-1] ^ add_ovf;

        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (op_p1)
            OP_AND:  result_d = a_p1 & b_p1;
            OP_OR:   result_d = a_p1 | b_p1;
            OP_XOR:  result_d = a_p1 ^ b_p1;
            OP_NOR:  result_d = ~(a_p1 | b_p1);
            OP_ADD: begin
                result_d = sum[n-1:0];
                carry_d  = sum[n];
                ovf_d    = add_ovf;
            end
            OP_SUB: begin
                result_d = sum[n-1:0];
                carry_d  = sum[n];
                ovf_d    = add_ovf;
            end
            OP_SLT: begin
                result_d = {{(n-1){1'b0}}, slt_bit};
                carry_d  = sum[n];
            end
            default: result_d = a_p1;
        endcase
        zero_d = (result_d == '0);
    end

    // ---- stage 2: result and flags ----
    alu_pipe_reg #(.W(S2_W)) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .load     (s2_adv),
        .vld_in   (vld_p1),
        .data_in  ({result_d, zero_d, carry_d, ovf_d}),
        .vld_out  (vld_p2),
        .data_out (data_p2)
    );

    assign out_valid = vld_p2;
    assign {out_result, out_zero, out_carry, out_overflow} = data_p2;

endmodule

// File: tb/tb_alu_pipe_stage.sv
// Bench for alu_pipe_stage: directed cases plus randomized traffic, checked
// every cycle against an in-order queue of expected results.
module tb_alu_pipe_stage;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_result;
    logic          out_zero;
    logic          out_carry;
    logic          out_overflow;

    always #5 clk = ~clk;

    alu_pipe_stage #(.n(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_overflow (out_overflow)
    );

    typedef struct {
        logic [N-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        int           t;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    // Reference ALU from the arithmetic definitions: {result, zero, carry, overflow}.
    function automatic logic [N+2:0] ref_alu(input logic [2:0] op,
                                             input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        longint       sa, sb, sr, smax, smin;
        logic [N-1:0] r;
        logic         c, v;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) << (N - 1)) - 1;
        smin = -(longint'(1) << (N - 1));
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a | b);
            3'd4: begin
                r  = a + b;
                c  = (longint'(a) + longint'(b)) >= (longint'(1) << N);
                sr = sa + sb;
                v  = (sr > smax) || (sr < smin);
            end
            3'd5: begin
                r  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr > smax) || (sr < smin);
            end
            3'd6: begin
                r = (sa < sb) ? N'(1) : N'(0);
                c = (a >= b);
            end
            default: r = a;
        endcase
        return {r, (r == '0), c, v};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---- scoreboard: apply last edge's events, then compare outputs ----
    logic         p_rst   = 1'b0;
    logic         p_acc   = 1'b0;
    logic         p_cons  = 1'b0;
    exp_t         p_item;
    logic         chk_en  = 1'b0;
    logic         just_rst;
    logic         hold_prev = 1'b0;
    logic [N+2:0] prev_out;

    always @(negedge clk) begin
        logic [N+2:0] r;
        logic         exp_ir;
        logic         exp_ov;
        cyc++;
        just_rst = 1'b0;
        if (p_rst) begin
            q.delete();
            just_rst = 1'b1;
            chk_en   = 1'b1;
        end else begin
            if (p_cons && q.size() > 0) void'(q.pop_front());
            if (p_acc) begin
                p_item.t = cyc;
                q.push_back(p_item);
            end
        end

        if (chk_en) begin
            exp_ir = !(q.size() >= 2 && !out_ready);
            check("in_ready", 64'(in_ready), 64'(exp_ir));
            exp_ov = (q.size() > 1) || (q.size() == 1 && q[0].t != cyc);
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            if (out_valid && exp_ov)
                check("result_flags", 64'({out_result, out_zero, out_carry, out_overflow}),
                      64'({q[0].res, q[0].z, q[0].c, q[0].v}));
            if (just_rst)
                check("reset_outputs", 64'({out_result, out_zero, out_carry, out_overflow}), 64'(0));
            if (hold_prev)
                check("stall_stable", 64'({out_result, out_zero, out_carry, out_overflow}),
                      64'(prev_out));
        end

        hold_prev = chk_en && out_valid && !out_ready && !rst;
        prev_out  = {out_result, out_zero, out_carry, out_overflow};
        p_rst     = rst;
        p_cons    = out_valid && out_ready;
        p_acc     = in_valid && in_ready;
        if (p_acc) begin
            r = ref_alu(in_op, in_a, in_b);
            p_item.res = r[N+2:3];
            p_item.z   = r[2];
            p_item.c   = r[1];
            p_item.v   = r[0];
        end
    end

    // ---- stimulus ----
    task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [N-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [N+2:0] pin;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Hand-computed values pinning the reference model.
        pin = ref_alu(3'd4, 32'h7FFF_FFFF, 32'h0000_0001);
        check("pin_add_ovf", 64'(pin), 64'({32'h8000_0000, 1'b0, 1'b0, 1'b1}));
        pin = ref_alu(3'd5, 32'h0000_0005, 32'h0000_0005);
        check("pin_sub_zero", 64'(pin), 64'({32'h0, 1'b1, 1'b1, 1'b0}));
        pin = ref_alu(3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
        check("pin_slt_neg", 64'(pin), 64'({32'h1, 1'b0, 1'b1, 1'b0}));
        pin = ref_alu(3'd1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        check("pin_or", 64'(pin), 64'({32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}));
        pin = ref_alu(3'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        check("pin_nor", 64'(pin), 64'({32'h0, 1'b1, 1'b0, 1'b0}));
        pin = ref_alu(3'd2, 32'hAAAA_5555, 32'hFFFF_0000);
        check("pin_xor", 64'(pin), 64'({32'h5555_5555, 1'b0, 1'b0, 1'b0}));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset held three cycles in the middle of traffic.
        send(3'd4, 32'h1, 32'h2);
        send(3'd7, 32'h1234_5678, 32'h0);
        in_valid = 1'b1;
        in_op    = 3'd2;
        in_a     = 32'hDEAD_BEEF;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_result", 64'(out_result), 64'(0));
        @(posedge clk);
        #1;

        // Directed operations.
        send(3'd4, 32'h7FFF_FFFF, 32'h0000_0001);
        send(3'd5, 32'h0000_0005, 32'h0000_0005);
        send(3'd6, 32'hFFFF_FFFF, 32'h0000_0001);
        send(3'd1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        send(3'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        send(3'd2, 32'hAAAA_5555, 32'hFFFF_0000);
        repeat (3) @(posedge clk);
        #1;

        // Eight back-to-back operations with the sink always ready.
        for (int i = 0; i < 8; i++) send(3'(i), rnd_val(), rnd_val());
        repeat (3) @(posedge clk);
        #1;

        // Full stall: third operation must wait while the sink is blocked.
        out_ready = 1'b0;
        send(3'd4, 32'h10, 32'h20);
        send(3'd5, 32'h10, 32'h20);
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'hFFFF_0000;
        in_b     = 32'h0FF0_0FF0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        send(3'd0, 32'hFFFF_0000, 32'h0FF0_0FF0);
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_op     = 3'($urandom_range(0, 7));
            in_a      = rnd_val();
            in_b      = rnd_val();
            out_ready = ($urandom_range(0, 9) < 6);
            if (i > 500 && i < 520) rst = ($urandom_range(0, 3) == 0);
            else rst = 1'b0;
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drained", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
